// File: rtl/pipeline_periph_bus_if.sv
// Memory-side bus between the pipelined MIPS core's MEM stage and the peripheral bus slave.
// The master drives address, strobes and store data; the slave returns read data combinationally.
interface pipeline_periph_bus_if;
    logic [31:0] iMemAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iMemWriteData;
    logic [31:0] oMemReadData;

    modport master (
        output iMemAddr,
        output iMemRead,
        output iMemWrite,
        output iMemWriteData,
        input  oMemReadData
    );

    modport slave (
        input  iMemAddr,
        input  iMemRead,
        input  iMemWrite,
        input  iMemWriteData,
        output oMemReadData
    );
endinterface

// File: rtl/pipeline_periph_bus.sv
// Bus slave for the MIPS MEM stage: data RAM, timer, LEDs, switches, 7-seg register.
// Optional free-running SYSTICK counter is built when PERIPH_SYSTICK_EN is defined.
module pipeline_periph_bus #(
    parameter int RAM_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_periph_bus_if.slave  bus,
    output logic                  oInterrupt,
    input  logic [7:0]            iSwitch,
    output logic [7:0]            oLED,
    output logic [11:0]           oDigi
);

    localparam int RAM_AW = $clog2(RAM_WORDS);

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
    localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
    localparam logic [31:0] ADDR_DIGI    = 32'h4000_0014;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0018;

    logic [31:0]       ram_r [RAM_WORDS];
    logic [31:0]       th_r;
    logic [31:0]       tl_r;
    logic [2:0]        tcon_r;
    logic [7:0]        led_r;
    logic [11:0]       digi_r;
    logic [7:0]        switchSync1_r;
    logic [7:0]        switchSync2_r;
    logic              irq_r;

    logic [31:0]       addr_s;
    logic              ramHit_s;
    logic [RAM_AW-1:0] ramIdx_s;
    logic              wrRam_s;
    logic              wrTh_s;
    logic              wrTl_s;
    logic              wrTcon_s;
    logic              wrLed_s;
    logic              wrDigi_s;
    logic              tlAtMax_s;
    logic              ovfSet_s;
    logic [31:0]       nextTl_s;
    logic [2:0]        nextTcon_s;
    logic [31:0]       systickRead_s;
    logic [31:0]       readData_s;

    // Byte-lane bits are masked off so every decode works on the aligned word address.
    assign addr_s    = bus.iMemAddr & 32'hFFFF_FFFC;
    assign ramHit_s  = (addr_s >> (RAM_AW + 2)) == 32'd0;
    assign ramIdx_s  = addr_s[RAM_AW+1:2];

    assign wrRam_s   = bus.iMemWrite & ramHit_s;
    assign wrTh_s    = bus.iMemWrite & (addr_s == ADDR_TH);
    assign wrTl_s    = bus.iMemWrite & (addr_s == ADDR_TL);
    assign wrTcon_s  = bus.iMemWrite & (addr_s == ADDR_TCON);
    assign wrLed_s   = bus.iMemWrite & (addr_s == ADDR_LED);
    assign wrDigi_s  = bus.iMemWrite & (addr_s == ADDR_DIGI);

    assign tlAtMax_s = (tl_r == 32'hFFFF_FFFF);

    // Timer next state: a CPU write to TL overrides counting and suppresses that overflow.
    always_comb begin
        ovfSet_s = 1'b0;
        if (wrTl_s) begin
            nextTl_s = bus.iMemWriteData;
        end else if (tcon_r[0]) begin
            if (tlAtMax_s) begin
                nextTl_s = th_r;
                ovfSet_s = tcon_r[1];
            end else begin
                nextTl_s = tl_r + 32'd1;
            end
        end else begin
            nextTl_s = tl_r;
        end

        // Status is OR-ed with a coincident overflow so a TCON write never loses an interrupt.
        if (wrTcon_s) begin
            nextTcon_s = {bus.iMemWriteData[2] | ovfSet_s, bus.iMemWriteData[1:0]};
        end else begin
            nextTcon_s = {tcon_r[2] | ovfSet_s, tcon_r[1:0]};
        end
    end

    // Peripheral and timer registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_r          <= 32'd0;
            tl_r          <= 32'd0;
            tcon_r        <= 3'd0;
            led_r         <= 8'd0;
            digi_r        <= 12'd0;
            switchSync1_r <= 8'd0;
            switchSync2_r <= 8'd0;
            irq_r         <= 1'b0;
        end else begin
            if (wrTh_s) begin
                th_r <= bus.iMemWriteData;
            end
            if (wrLed_s) begin
                led_r <= bus.iMemWriteData[7:0];
            end
            if (wrDigi_s) begin
                digi_r <= bus.iMemWriteData[11:0];
            end
            tl_r          <= nextTl_s;
            tcon_r        <= nextTcon_s;
            irq_r         <= nextTcon_s[1] & nextTcon_s[2];
            switchSync1_r <= iSwitch;
            switchSync2_r <= switchSync1_r;
        end
    end

    // Data RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wrRam_s) begin
            ram_r[ramIdx_s] <= bus.iMemWriteData;
        end
    end

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick_r;

    // Free-running cycle counter, wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick_r <= 32'd0;
        end else begin
            systick_r <= systick_r + 32'd1;
        end
    end

    assign systickRead_s = systick_r;
`else
    assign systickRead_s = 32'd0;
`endif

    // Zero-latency read mux so the MEM/WB register captures load data the same cycle.
    always_comb begin
        readData_s = 32'd0;
        if (!bus.iMemRead) begin
            readData_s = 32'd0;
        end else if (ramHit_s) begin
            readData_s = ram_r[ramIdx_s];
        end else begin
            case (addr_s)
                ADDR_TH:      readData_s = th_r;
                ADDR_TL:      readData_s = tl_r;
                ADDR_TCON:    readData_s = {29'd0, tcon_r};
                ADDR_LED:     readData_s = {24'd0, led_r};
                ADDR_SWITCH:  readData_s = {24'd0, switchSync2_r};
                ADDR_DIGI:    readData_s = {20'd0, digi_r};
                ADDR_SYSTICK: readData_s = systickRead_s;
                default:      readData_s = 32'd0;
            endcase
        end
    end

    assign bus.oMemReadData = readData_s;
    assign oInterrupt       = irq_r;
    assign oLED             = led_r;
    assign oDigi            = digi_r;

endmodule
